// File: rtl/sata_dma_stream_pkg.sv
// Shared helpers for the SATA DMA stream blocks.
// Destination-index width used to size select fields and slice payloads.
package sata_dma_stream_pkg;

  // clog2 that never returns 0, so a 1-bit index field always exists.
  function automatic int idx_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sata_dma_stream_skid.sv
// Generic 2-entry register slice: registered input ready, 1-cycle latency,
// full throughput. Main is the head entry; skid catches the beat in flight on a stall.
module sata_dma_stream_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_dat_i,
  input  logic             in_val_i,
  output logic             in_rdy_o,
  output logic [WIDTH-1:0] out_dat_o,
  output logic             out_val_o,
  input  logic             out_rdy_i
);

  logic [WIDTH-1:0] main_dat_q, main_dat_d;
  logic [WIDTH-1:0] skid_dat_q, skid_dat_d;
  logic             main_val_q, main_val_d;
  logic             skid_val_q, skid_val_d;
  logic             rdy_q, rdy_d;
  logic             acc, fire;

  assign acc  = in_val_i & rdy_q;
  assign fire = main_val_q & out_rdy_i;

  always_comb begin
    main_dat_d = main_dat_q;
    main_val_d = main_val_q;
    skid_dat_d = skid_dat_q;
    skid_val_d = skid_val_q;
    if (!main_val_q || fire) begin
      // Head is free this cycle: refill from skid first to preserve order.
      if (skid_val_q) begin
        main_dat_d = skid_dat_q;
        main_val_d = 1'b1;
        skid_val_d = 1'b0;
      end else if (acc) begin
        main_dat_d = in_dat_i;
        main_val_d = 1'b1;
      end else begin
        main_val_d = 1'b0;
      end
    end else if (acc) begin
      skid_dat_d = in_dat_i;
      skid_val_d = 1'b1;
    end
    rdy_d = !skid_val_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_dat_q <= '0;
      main_val_q <= 1'b0;
      skid_dat_q <= '0;
      skid_val_q <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      main_dat_q <= main_dat_d;
      main_val_q <= main_val_d;
      skid_dat_q <= skid_dat_d;
      skid_val_q <= skid_val_d;
      rdy_q      <= rdy_d;
    end
  end

  assign in_rdy_o  = rdy_q;
  assign out_dat_o = main_dat_q;
  assign out_val_o = main_val_q;

endmodule

// File: rtl/sata_dma_stream_demux.sv
// Packet-aware 1-to-OUTPUTS stream demultiplexer. The destination is sampled on
// the first beat of a packet and held until eop; a 2-entry slice carries {dst, eop, dat}.
module sata_dma_stream_demux
  import sata_dma_stream_pkg::*;
#(
  parameter int OUTPUTS = 2,
  parameter int WIDTH   = 8
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [idx_width(OUTPUTS)-1:0]         select,
  input  logic [WIDTH-1:0]                      i_dat,
  input  logic                                  i_val,
  input  logic                                  i_eop,
  output logic                                  i_rdy,
  output logic [OUTPUTS-1:0][WIDTH-1:0]         o_dat,
  output logic [OUTPUTS-1:0]                    o_val,
  output logic [OUTPUTS-1:0]                    o_eop,
  input  logic [OUTPUTS-1:0]                    o_rdy,
  output logic                                  busy
);

  localparam int SEL_W = idx_width(OUTPUTS);
  localparam int ENT_W = WIDTH + 1 + SEL_W;

  logic [SEL_W-1:0] sel_safe;
  logic [SEL_W-1:0] dst;
  logic [SEL_W-1:0] lock_sel_q;
  logic             locked_q;
  logic             acc;

  logic [ENT_W-1:0] main_ent;
  logic             main_val;
  logic [SEL_W-1:0] main_dst;
  logic             main_eop;
  logic [WIDTH-1:0] main_dat;

  // Out-of-range indices fall back to output 0; impossible when OUTPUTS is a power of 2.
  generate
    if (OUTPUTS == (1 << SEL_W)) begin : g_sel_pow2
      assign sel_safe = select;
    end else begin : g_sel_clamp
      assign sel_safe = (select < SEL_W'(OUTPUTS)) ? select : '0;
    end
  endgenerate

  assign dst = locked_q ? lock_sel_q : sel_safe;
  assign acc = i_val & i_rdy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      locked_q   <= 1'b0;
      lock_sel_q <= '0;
    end else if (acc) begin
      if (i_eop) begin
        locked_q <= 1'b0;
      end else begin
        locked_q   <= 1'b1;
        lock_sel_q <= dst;
      end
    end
  end

  sata_dma_stream_skid #(
    .WIDTH(ENT_W)
  ) u_slice (
    .clk      (clk),
    .rst_n    (reset_n),
    .in_dat_i ({dst, i_eop, i_dat}),
    .in_val_i (i_val),
    .in_rdy_o (i_rdy),
    .out_dat_o(main_ent),
    .out_val_o(main_val),
    .out_rdy_i(o_rdy[main_dst])
  );

  assign {main_dst, main_eop, main_dat} = main_ent;

  genvar gi;
  generate
    for (gi = 0; gi < OUTPUTS; gi++) begin : g_lane
      assign o_val[gi] = main_val & (main_dst == SEL_W'(gi));
      assign o_eop[gi] = o_val[gi] & main_eop;
      assign o_dat[gi] = main_dat;
    end
  endgenerate

  assign busy = locked_q;

endmodule

// File: doc/sata_dma_stream_demux.md
Name: sata_dma_stream_demux

Overview:
Packet-aware demultiplexer: routes one input stream to one of OUTPUTS output streams. It is the distribution counterpart of the DMA stream multiplexer and lets one producer feed several consumers, e.g. read data to per-command buffers. The destination is sampled on the first beat of each packet and held until the eop beat. A 2-entry register slice gives a registered i_rdy, 1-cycle latency and full throughput.

Parameters:
OUTPUTS, 2, number of output streams; must be >= 2.
WIDTH, 8, data width in bits.

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous reset, active low
select  input  $clog2(OUTPUTS)  destination index; sampled only on the first beat of a packet
i_dat  input  WIDTH  input data
i_val  input  1  input valid
i_eop  input  1  last beat of packet
i_rdy  output  1  input ready (registered)
o_dat  output  [OUTPUTS][WIDTH]  output data; every lane carries the same head word
o_val  output  OUTPUTS  output valid; one-hot or zero
o_eop  output  OUTPUTS  eop per output; qualified by o_val
o_rdy  input  OUTPUTS  output ready
busy  output  1  a packet is mid-flight at the input; destination is locked

Behaviour:
- Reset (async, reset_n=0): main_val=0, skid_val=0, locked=0, lock_sel=0, i_rdy=0, o_val=0, o_eop=0, busy=0.
- o_dat reset value: 0.
- i_rdy is a register. It goes to 1 on the first clk edge after reset release.
- i_rdy(next) = !skid_val(next).
- Input beat is accepted when i_val & i_rdy.
- Destination: dst = locked ? lock_sel : select.
  - Accepted beat with !i_eop: locked<=1, lock_sel<=dst.
  - Accepted beat with i_eop: locked<=0.
  - A single-beat packet never locks.
- Changes on select while locked are ignored.
- select >= OUTPUTS while sampled: beat is routed to output 0.
- busy = locked.
- Slice entries hold {dst, eop, dat}. Head entry = main.
  - o_val[k] = main_val & (main_dst==k).
  - o_eop[k] = o_val[k] & main_eop.
  - o_dat[k] = main_dat for all k.
- Output fire: fire = main_val & o_rdy[main_dst].
- Per-cycle slice update, given accept (acc) and fire:
  - main empty & acc: load main. Beat appears on the output the next cycle, so latency = 1.
  - main full, fire, !skid_val, acc: main <= input.
  - main full, !fire, acc: skid <= input; i_rdy drops the next cycle.
  - skid full & fire: main <= skid, skid_val<=0, i_rdy rises the next cycle.
  - fire & !acc & !skid_val: main_val<=0.
- Sustained i_val with the destination o_rdy=1 gives 1 beat per cycle with no bubbles.
- o_rdy of non-selected outputs has no effect.
- A stalled destination blocks all traffic (head-of-line). This is intentional because packet order is preserved.
- Output valid/data must not change while o_val[k]=1 & o_rdy[k]=0.
- Reset mid-packet clears all state and drops in-flight beats. The next accepted beat samples select.

Decomposition:
- Shared package sata_dma_stream_pkg: function for the destination-index width (clog2 with a minimum of 1). Not a typedef; the slice entry width is WIDTH + 1 + index width.
- Sub-module sata_dma_stream_skid: generic 2-entry register slice (parameter WIDTH) with val/rdy on both sides and registered input ready.
- The demux instantiates the slice with payload {dst, eop, dat}, adds the lock logic, and decodes o_val/o_eop.

Test Plan:
- Reset release, OUTPUTS=4, WIDTH=8 -> i_rdy=0 during reset, 1 one cycle after release; o_val=0000.
- Packet 0x11,0x22,0x33(eop) with select=2, o_rdy=1111 -> o_val=0100 for 3 consecutive cycles starting 1 cycle after the first accept; o_eop[2] only on 0x33.
- Mid-packet select change: select=1 on beat 0, then select=3 for beats 1-3 of a 4-beat packet -> all 4 beats on output 1; busy=1 from beat 0 acceptance until eop accepted; next packet goes to output 3.
- Backpressure: o_rdy[1]=0 for 5 cycles during a packet to output 1 -> i_rdy drops after 2 beats are buffered; o_dat[1] stable; no loss or duplication when o_rdy returns to 1; i_rdy rises 1 cycle later.
- Single-beat packets to 0,1,0,1 back-to-back with o_rdy=11 -> 1 beat per cycle; busy stays 0; destinations alternate.
- Head-of-line: packet to output 0 with o_rdy[0]=0, then packet to output 1 with o_rdy[1]=1 -> output 1 receives nothing until output 0 drains.
- Reset asserted mid-packet -> o_val=0 immediately; after release the first beat uses the current select.
